// File: rtl/sipo_latch_loader_pkg.sv
// sipo_latch_loader_pkg: shared state encoding and default sizing for the SIPO latch loader.
package sipo_latch_loader_pkg;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_EN_CYCLES = 2;
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/sipo_latch_loader_if.sv
// sipo_latch_loader_if: serial input and latch-bank output bundle of the SIPO latch loader.
interface sipo_latch_loader_if
    import sipo_latch_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sdi;
    logic             sdi_valid;
    logic [WIDTH-1:0] latch_d;
    logic             latch_en;
    logic             busy;
    logic             done;
    logic             err;
    modport master (output start, sdi, sdi_valid, input latch_d, latch_en, busy, done, err);
    modport slave  (input start, sdi, sdi_valid, output latch_d, latch_en, busy, done, err);
endinterface

// File: rtl/sipo_latch_loader_shift_reg.sv
// sipo_shift_reg: MSB-first shift register with bit counter and running even parity.
module sipo_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             sdi,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    cnt,
    output logic             par
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
            par <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            cnt <= '0;
            par <= 1'b0;
        end else if (shift) begin
            q   <= {q[WIDTH-2:0], sdi};
            cnt <= cnt + 1'b1;
            par <= par ^ sdi;
        end
    end
endmodule

// File: rtl/sipo_latch_loader.sv
// sipo_latch_loader: assembles a serial word and strobes it into a latch bank with setup/hold margins.
// Define PARITY_EN to expect an even-parity bit after each word and report mismatches on err.
module sipo_latch_loader
    import sipo_latch_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EN_CYCLES = DEF_EN_CYCLES
) (
    input logic                clk,
    input logic                rst,
    sipo_latch_loader_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int EW = $clog2(EN_CYCLES + 1);

    state_t           state;
    logic [EW-1:0]    ecnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             en_q;
    logic             done_q;
    logic             shift;
    logic             last;

    assign shift = (state == SHIFT) && bus.sdi_valid;
    assign last  = shift && (cnt == CW'(WIDTH - 1));

    sipo_shift_reg #(.WIDTH(WIDTH), .CW(CW)) u_sr (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) && bus.start),
        .shift(shift),
        .sdi  (bus.sdi),
        .q    (q),
        .cnt  (cnt),
        .par  (par)
    );

`ifdef PARITY_EN
    logic err_q;
    assign bus.err = err_q;
`else
    logic unused_ok;
    assign unused_ok = ^{q[WIDTH-1], par};
    assign bus.err   = 1'b0;
`endif

    assign bus.latch_d  = d_q;
    assign bus.latch_en = en_q;
    assign bus.done     = done_q;
    assign bus.busy     = state != IDLE;

    // latch_d only moves on SETUP entry, so it is settled a full cycle before latch_en rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ecnt   <= '0;
            d_q    <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef PARITY_EN
            err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef PARITY_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE:   if (bus.start) state <= SHIFT;
                SHIFT:  if (last) begin
`ifdef PARITY_EN
                    state <= PARITY;
`else
                    state <= SETUP;
                    d_q   <= {q[WIDTH-2:0], bus.sdi};
`endif
                end
`ifdef PARITY_EN
                PARITY: if (bus.sdi_valid) begin
                    if (bus.sdi == par) begin
                        state <= SETUP;
                        d_q   <= q;
                    end else begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end
                end
`endif
                SETUP: begin
                    state <= STROBE;
                    en_q  <= 1'b1;
                    ecnt  <= '0;
                end
                STROBE: if (ecnt == EW'(EN_CYCLES - 1)) begin
                    state  <= HOLD;
                    en_q   <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    ecnt <= ecnt + 1'b1;
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_latch_loader.sv
// tb_sipo_latch_loader: directed plus randomized frames checked cycle by cycle against a timeline model.
module tb_sipo_latch_loader;
    import sipo_latch_loader_pkg::*;
    localparam int W = DEF_WIDTH;
`ifdef PARITY_EN
    localparam int EN = 1;
    localparam int NB = W + 1;
`else
    localparam int EN = DEF_EN_CYCLES;
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [W-1:0] prev = '0;
    logic [W-1:0] ab;

    sipo_latch_loader_if #(.WIDTH(W)) bus();
    sipo_latch_loader #(.WIDTH(W), .EN_CYCLES(EN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_out(input string ph, input logic [W-1:0] d, input logic en, input logic busy,
                           input logic done, input logic err);
        chk({ph, ".latch_d"}, 32'(bus.latch_d), 32'(d));
        chk({ph, ".latch_en"}, 32'(bus.latch_en), 32'(en));
        chk({ph, ".busy"}, 32'(bus.busy), 32'(busy));
        chk({ph, ".done"}, 32'(bus.done), 32'(done));
        chk({ph, ".err"}, 32'(bus.err), 32'(err));
    endtask

    // Frame timeline: L = cycle the final frame bit is taken; word visible from L+1,
    // strobe L+2..L+1+EN, done at L+2+EN; a parity miss gives err at L+1 and no strobe.
    task automatic run_frame(input logic [W-1:0] w, input logic pb, input int vmode, input bit poke);
        logic [NB-1:0] bits;
        logic v;
        bit good;
        int nb = 0;
        int L = -1;
        int H = 1 << 30;
`ifdef PARITY_EN
        bits = {w, pb};
        good = (pb == ^w);
`else
        bits = w;
        good = 1'b1 | pb;
`endif
        bus.start     = 1'b1;
        bus.sdi_valid = 1'($urandom);
        bus.sdi       = 1'($urandom);
        for (int c = 1; c <= H + 1; c++) begin
            tick;
            chk_out("frame", (good && L >= 0 && c > L) ? w : prev,
                    good && L >= 0 && c >= L + 2 && c <= L + 1 + EN,
                    c <= H, good && c == H, !good && c == H + 1);
            if (c <= H) begin
                bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                if (nb < NB) begin
                    v = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(c % 2) :
                        1'((c % 3 != 0) || ($urandom_range(0, 1) == 1));
                    bus.sdi_valid = v;
                    bus.sdi       = v ? bits[NB-1-nb] : 1'($urandom);
                    if (v) begin
                        nb++;
                        if (nb == NB) begin
                            L = c;
                            H = good ? L + 2 + EN : L;
                        end
                    end
                end else begin
                    bus.sdi_valid = 1'($urandom);
                    bus.sdi       = 1'($urandom);
                end
            end
        end
        bus.start     = 1'b0;
        bus.sdi_valid = 1'b0;
        if (good) prev = w;
    endtask

    initial begin
        logic [W-1:0] w;
        bus.start     = 1'b0;
        bus.sdi       = 1'b0;
        bus.sdi_valid = 1'b0;
        tick;
        tick;
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick;
        chk_out("post_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_frame(8'hA5, 1'b0, 0, 1'b0);
        run_frame(8'hA5, 1'b0, 1, 1'b0);
        run_frame(8'h3E, 1'b1, 0, 1'b1);
        run_frame(8'hC7, 1'b1, 2, 1'b1);

        ab = 8'h3C;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sdi_valid = 1'b1;
            bus.sdi       = ab[W-1-i];
            tick;
        end
        bus.sdi_valid = 1'b0;
        chk_out("pre_abort", prev, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        rst  = 1'b0;
        prev = '0;
        run_frame(8'h81, 1'b0, 0, 1'b0);

        run_frame(8'hA5, 1'b0, 0, 1'b0);
        run_frame(8'h5A, 1'b1, 0, 1'b0);
        run_frame(8'hFF, 1'b0, 0, 1'b0);
        run_frame(8'h00, 1'b0, 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            w = W'($urandom);
            run_frame(w, (^w) ^ ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sipo_latch_loader.md
# sipo_latch_loader

Synchronous serial-in/parallel-out loader that feeds the team's async-reset D-latch bank. It assembles a WIDTH-bit word from a bit-serial stream and presents it on a stable parallel bus. It then drives the latch enable with guaranteed setup and hold cycles around the strobe, so the downstream transparent latches never see data changing while enabled.

## Interface
- WIDTH, 8, parallel word width (≥2)
- EN_CYCLES, 2, cycles latch_en is held high (≥1)
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle frame-start pulse
- sdi  input  1  serial data bit, MSB first
- sdi_valid  input  1  qualifies sdi for the current cycle
- latch_d  output  WIDTH  parallel data to latch bank d inputs
- latch_en  output  1  latch bank enable
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a word has been fully delivered
- err  output  1  one-cycle parity-error pulse (tied 0 without PARITY_EN)

## Operation
- Reset values: latch_d=0, latch_en=0, busy=0, done=0, err=0; state=IDLE; shift register and counters cleared.
- States: IDLE, SHIFT, PARITY (only with PARITY_EN), SETUP, STROBE, HOLD.
- IDLE: start=1 → SHIFT with the bit counter cleared. sdi and sdi_valid are ignored.
- SHIFT: on each cycle with sdi_valid=1, the shift register shifts left and takes sdi into its LSB, and the counter increments. Cycles with sdi_valid=0 hold all state, with no timeout.
  - When the valid bit with counter==WIDTH-1 is accepted, go to SETUP, or to PARITY if PARITY_EN is defined.
- PARITY: the next valid bit is the even-parity bit.
  - Match → SETUP.
  - Mismatch → err pulses for 1 cycle and the FSM returns to IDLE. latch_d is unchanged and latch_en never rises.
- SETUP: latch_d loads the shift register; latch_en=0. Lasts 1 cycle.
- STROBE: latch_en=1 for exactly EN_CYCLES cycles; latch_d held.
- HOLD: latch_en=0 and latch_d held for 1 cycle. The FSM then returns to IDLE with done=1 in that same HOLD cycle.
- latch_d changes only on SETUP entry and holds its value indefinitely between frames.
- start asserted outside IDLE is ignored, with no queuing. start in the HOLD cycle is also ignored.
- Counter width is $clog2(WIDTH), and its wrap is never used. The EN_CYCLES counter width is $clog2(EN_CYCLES+1).
- Async rst at any point forces the reset values immediately. Any partial frame is discarded.

## Timing
- Cycle 0: start sampled. Cycle 1: SHIFT begins.
- With continuous sdi_valid and no parity, the last data bit is accepted at cycle WIDTH. SETUP is at WIDTH+1, and latch_en is high for cycles WIDTH+2 … WIDTH+1+EN_CYCLES. HOLD/done is at WIDTH+2+EN_CYCLES, and the next start is accepted in the cycle after that.
- PARITY_EN adds exactly one valid-bit cycle before SETUP.
- latch_en is registered and glitch-free. latch_d is stable ≥1 cycle before latch_en rises and ≥1 cycle after it falls.
- busy rises the cycle after start is accepted and falls the cycle after HOLD.

## Configuration
- PARITY_EN defined: the PARITY state is present and one even-parity bit is expected after each word. err is active.
- PARITY_EN undefined: no PARITY state and err is constant 0. The frame is WIDTH bits.

## Structure
- The shared package holds the state enum typedef (IDLE, SHIFT, PARITY, SETUP, STROBE, HOLD) and the default WIDTH/EN_CYCLES constants.
- One sub-module is natural: sipo_shift_reg, holding the WIDTH-bit shift register, the bit counter, and running parity. The FSM and strobe timer stay in the top module.

## Test plan
- Reset, then start, then 0xA5 MSB-first with continuous valid:
  - latch_d=0xA5 from cycle 9.
  - latch_en high in cycles 10–11.
  - done in cycle 12.
  - busy falls in cycle 13.
- Same frame with sdi_valid low on alternate cycles: identical latch_d=0xA5 and strobe shape; the strobe is delayed by 7 cycles.
- start pulsed mid-SHIFT and during STROBE: ignored, with no extra done and the frame unchanged. A start the cycle after busy falls is accepted.
- rst asserted after 4 bits of 0x3C, then a full 0x81 frame:
  - Outputs are 0 immediately on rst.
  - The next frame yields latch_d=0x81 with no residue.
- PARITY_EN with EN_CYCLES=1:
  - 0xA5 with parity bit 0: latch_en high for 1 cycle.
  - 0x5A with parity bit 1: err pulse, latch_d stays 0xA5, no latch_en.
- Back-to-back frames 0xFF then 0x00: latch_d never changes while latch_en=1.
